// File: rtl/clk_div_meter.sv
// clk_div_meter: samples a divided clock on clk and measures its high, low
// and total period lengths, tracking lock against the expected divide ratio.
module clk_div_meter #(
    parameter int CNT_W   = 8,
    parameter int EXP_DIV = 6,
    parameter int LOCK_N  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic [CNT_W:0]   period,
    output logic             valid,
    output logic             locked,
    output logic             err
);

    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_N);
    localparam logic [MW-1:0]    M_ONE  = MW'(1);
    localparam logic [CNT_W:0]   EXP_P  = (CNT_W+1)'(EXP_DIV);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAXC   = '1;

    typedef enum logic [1:0] {
        S_WAIT,
        S_HIGH,
        S_LOW
    } state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [MW-1:0]    match_q, match_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W:0]   per_q, per_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;

    logic             rise, fall;
    logic             report, timeout;
    logic [CNT_W:0]   sum;

    assign rise = s1_q & ~s2_q;
    assign fall = ~s1_q & s2_q;
    assign sum  = {1'b0, hcnt_q} + {1'b0, lcnt_q};

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        lcnt_d   = lcnt_q;
        match_d  = match_q;
        high_d   = high_q;
        low_d    = low_q;
        per_d    = per_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        err_d    = 1'b0;
        report   = 1'b0;
        timeout  = 1'b0;

        unique case (state_q)
            S_WAIT: begin
                if (rise) begin
                    state_d = S_HIGH;
                    hcnt_d  = ONE;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    state_d = S_LOW;
                    lcnt_d  = ONE;
                end else if (s1_q) begin
                    if (hcnt_q == MAXC) timeout = 1'b1;
                    else                hcnt_d  = hcnt_q + ONE;
                end
            end
            S_LOW: begin
                if (rise) begin
                    report = 1'b1;
                end else if (!s1_q) begin
                    if (lcnt_q == MAXC) timeout = 1'b1;
                    else                lcnt_d  = lcnt_q + ONE;
                end
            end
            default: state_d = S_WAIT;
        endcase

        // The rise that closes one period also opens the next high phase.
        if (report) begin
            state_d = S_HIGH;
            hcnt_d  = ONE;
            lcnt_d  = '0;
            high_d  = hcnt_q;
            low_d   = lcnt_q;
            per_d   = sum;
            valid_d = 1'b1;
            if (sum == EXP_P) begin
                match_d  = (match_q == LOCK_M) ? match_q : match_q + M_ONE;
                locked_d = (match_d == LOCK_M);
            end else begin
                err_d    = 1'b1;
                match_d  = '0;
                locked_d = 1'b0;
            end
        end

        if (timeout) begin
            state_d  = S_WAIT;
            err_d    = 1'b1;
            match_d  = '0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            state_q  <= S_WAIT;
            hcnt_q   <= '0;
            lcnt_q   <= '0;
            match_q  <= '0;
            high_q   <= '0;
            low_q    <= '0;
            per_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_q     <= div_in;
            s2_q     <= s1_q;
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            match_q  <= match_d;
            high_q   <= high_d;
            low_q    <= low_d;
            per_q    <= per_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign high_time = high_q;
    assign low_time  = low_q;
    assign period    = per_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign err       = err_q;

endmodule

// File: tb/tb_clk_div_meter.sv
// tb_clk_div_meter: directed and random div_in waveforms checked against a
// run-length reference model of the period meter.
module tb_clk_div_meter;

    localparam int CNT_W   = 8;
    localparam int EXP_DIV = 6;
    localparam int LOCK_N  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             div_in = 1'b0;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic [CNT_W:0]   period;
    logic             valid;
    logic             locked;
    logic             err;

    always #5 clk = ~clk;

    clk_div_meter #(
        .CNT_W  (CNT_W),
        .EXP_DIV(EXP_DIV),
        .LOCK_N (LOCK_N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .div_in   (div_in),
        .high_time(high_time),
        .low_time (low_time),
        .period   (period),
        .valid    (valid),
        .locked   (locked),
        .err      (err)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int valids_seen = 0;
    int errs_seen   = 0;

    // Reference model: sample history since reset, analysed as runs.
    bit hist[$];
    int r0 = -1;
    int mcount = 0;
    logic [CNT_W-1:0] exp_h, exp_l;
    logic [CNT_W:0]   exp_p;
    logic             exp_v, exp_e, exp_lk;

    function automatic bit val(int i);
        return (i < 0) ? 1'b1 : hist[i];
    endfunction

    function automatic bit is_rise(int i);
        return val(i) && !val(i - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        r0 = -1;
        mcount = 0;
        exp_h = '0; exp_l = '0; exp_p = '0;
        exp_v = 1'b0; exp_e = 1'b0; exp_lk = 1'b0;
    endtask

    task automatic model_sample(input bit x);
        int m, rp, h, l, st;
        hist.push_back(x);
        m = hist.size() - 1;
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (is_rise(m)) begin
            if (r0 >= 0) begin
                rp = r0;
                for (int i = m - 1; i >= r0; i--) begin
                    if (is_rise(i)) begin
                        rp = i;
                        break;
                    end
                end
                h = 0;
                while (val(rp + h)) h++;
                l = m - rp - h;
                exp_h = h[CNT_W-1:0];
                exp_l = l[CNT_W-1:0];
                exp_p = (CNT_W+1)'(h + l);
                exp_v = 1'b1;
                if (h + l == EXP_DIV) mcount++;
                else begin
                    mcount = 0;
                    exp_e = 1'b1;
                end
                exp_lk = (mcount >= LOCK_N);
            end else begin
                r0 = m;
            end
        end else if (r0 >= 0) begin
            st = m;
            while (st > 0 && val(st - 1) == x) st--;
            if (m - st + 1 == (1 << CNT_W)) begin
                exp_e = 1'b1;
                mcount = 0;
                exp_lk = 1'b0;
                r0 = -1;
            end
        end
    endtask

    task automatic step(input bit x);
        @(negedge clk);
        div_in = x;
        @(posedge clk);
        #1;
        check("valid", 32'(valid), 32'(exp_v));
        check("err", 32'(err), 32'(exp_e));
        check("locked", 32'(locked), 32'(exp_lk));
        check("meas", {7'd0, high_time, low_time, period},
              {7'd0, exp_h, exp_l, exp_p});
        if (valid) valids_seen++;
        if (err) errs_seen++;
        model_sample(x);
    endtask

    task automatic lh(input int l, input int h, input int reps);
        repeat (reps) begin
            repeat (l) step(1'b0);
            repeat (h) step(1'b1);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_high"}, 32'(high_time), 32'd0);
        check({tag, "_low"}, 32'(low_time), 32'd0);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset(input bit dval);
        #1;
        reset = 1'b0;
        div_in = dval;
        #1;
        check_zero("rst");
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic clear_counts();
        valids_seen = 0;
        errs_seen = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        model_reset();
        #1;
        reset = 1'b1;

        // 3H/3L from release: lock on the 4th report, no errors
        clear_counts();
        lh(3, 3, 9);
        check("t1_valids", 32'(valids_seen), 32'd8);
        check("t1_errs", 32'(errs_seen), 32'd0);
        check("t1_locked", 32'(locked), 32'd1);

        // wrong ratio drops lock, correct ratio relocks
        clear_counts();
        lh(5, 2, 2);
        check("t2_unlock", 32'(locked), 32'd0);
        lh(3, 3, 5);
        check("t2_errs", 32'(errs_seen), 32'd3);
        check("t2_relock", 32'(locked), 32'd1);

        // stuck high: single timeout, no report
        clear_counts();
        lh(3, 3, 1);
        repeat (297) step(1'b1);
        check("t3_errs", 32'(errs_seen), 32'd1);
        check("t3_valids", 32'(valids_seen), 32'd1);
        check("t3_locked", 32'(locked), 32'd0);
        lh(3, 3, 3);

        // reset in the low phase while locked
        lh(3, 3, 5);
        check("t4_locked", 32'(locked), 32'd1);
        step(1'b0);
        do_reset(1'b0);
        clear_counts();
        lh(3, 3, 2);
        check("t4_valids", 32'(valids_seen), 32'd1);

        // divide-by-2 input
        clear_counts();
        lh(1, 1, 10);
        step(1'b0);
        check("t5_valids", 32'(valids_seen), 32'd10);
        check("t5_errs", 32'(errs_seen), 32'd10);

        // div_in high across reset release
        do_reset(1'b1);
        clear_counts();
        repeat (5) step(1'b1);
        lh(3, 3, 1);
        check("t6_none", 32'(valids_seen + errs_seen), 32'd0);
        lh(3, 3, 3);
        check("t6_valids", 32'(valids_seen), 32'd3);

        // maximal phases, then a low-side timeout
        lh(255, 255, 2);
        check("t7_period", 32'(period), 32'd510);
        check("t7_high", 32'(high_time), 32'd255);
        lh(3, 3, 2);
        repeat (260) step(1'b0);
        lh(3, 3, 3);

        // random phases with bursts of the expected ratio
        repeat (150) begin
            if ($urandom_range(0, 3) == 0)
                lh(3, 3, int'($urandom_range(1, 6)));
            else
                lh(int'($urandom_range(1, 7)), int'($urandom_range(1, 7)), 1);
            if ($urandom_range(0, 49) == 0)
                do_reset(1'($urandom_range(0, 1)));
        end
        repeat (4) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
